// File: rtl/serial_adder32.sv
// Multi-cycle 32-bit adder: adds CHUNK bits per clock through a registered carry,
// behind a start/done handshake (IDLE -> RUN for 32/CHUNK cycles -> DONE).
module serial_adder32 #(
  parameter int CHUNK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);

  localparam int N  = 32 / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!(CHUNK == 1 || CHUNK == 2 || CHUNK == 4 || CHUNK == 8 ||
          CHUNK == 16 || CHUNK == 32)) begin : g_bad_chunk
      $error("serial_adder32: CHUNK must be 1, 2, 4, 8, 16 or 32");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     a_reg, b_reg, sum_reg;
  logic            carry_reg, cout_reg, ovf_reg;
  logic [CW-1:0]   cnt_reg;

  logic [CHUNK:0]  chunk_sum;
  logic [31:0]     a_shift, b_shift, sum_shift;
  logic            carry_into_msb;
  logic            last_chunk;

  assign chunk_sum = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                   + (CHUNK+1)'(carry_reg);
  // Carry into the chunk's top bit, recovered from its sum bit; on the final chunk this is bit 31.
  assign carry_into_msb = chunk_sum[CHUNK-1] ^ a_reg[CHUNK-1] ^ b_reg[CHUNK-1];
  assign last_chunk = (cnt_reg == CW'(N - 1));

  generate
    if (CHUNK == 32) begin : g_full
      assign a_shift   = '0;
      assign b_shift   = '0;
      assign sum_shift = chunk_sum[31:0];
    end else begin : g_part
      assign a_shift   = {{CHUNK{1'b0}}, a_reg[31:CHUNK]};
      assign b_shift   = {{CHUNK{1'b0}}, b_reg[31:CHUNK]};
      assign sum_shift = {chunk_sum[CHUNK-1:0], sum_reg[31:CHUNK]};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_reg     <= a_shift;
          b_reg     <= b_shift;
          sum_reg   <= sum_shift;
          carry_reg <= chunk_sum[CHUNK];
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_chunk) begin
            cout_reg <= chunk_sum[CHUNK];
            ovf_reg  <= chunk_sum[CHUNK] ^ carry_into_msb;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule
